// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
package loader_pkg;

  // Loader sequencing states.
  typedef enum logic [2:0] {
    COLLECT,
    CPU_RST,
    BURST,
    RELEASE,
    RUN
  } loaderState_e;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/loader_buffer.sv
// Word buffer: one write port, one read port, registered read data.
// The read register has a synchronous clear so the downstream bus idles at zero.
module loader_buffer #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wrEn,
  input  logic [AW-1:0] wrAddr,
  input  logic [31:0]   wrData,
  input  logic          rdEn,
  input  logic          rdClr,
  input  logic [AW-1:0] rdAddr,
  output logic [31:0]   rdData
);

  logic [31:0] mem [DEPTH];

  // Storage write; contents are not reset.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  // Registered read with clear taking priority.
  always_ff @(posedge clk) begin
    if (rdClr) begin
      rdData <= '0;
    end else if (rdEn) begin
      rdData <= mem[rdAddr];
    end
  end

endmodule

// File: rtl/program_loader.sv
// Program loader: packs a byte stream into words, then on go holds the CPU
// in reset, bursts every word on back-to-back cycles and releases the CPU.
module program_loader
  import loader_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int CNT_W      = $clog2(DEPTH) + 1,
  parameter int RST_CYCLES = 2
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  input  logic             go,
  output logic             cpu_reset,
  output logic             cpu_load,
  output logic [31:0]      cpu_instruction,
  output logic [CNT_W-1:0] word_count,
  output logic             busy,
  output logic             done
);

  localparam int AW    = $clog2(DEPTH);
  localparam int IDX_W = $clog2(BYTES_PER_WORD);
  localparam int RC_W  = $clog2(RST_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [RC_W-1:0]  RST_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES_PER_WORD - 1);

  loaderState_e     stateReg, stateNext;
  logic [CNT_W-1:0] wordCountReg, wordCountNext;
  logic [IDX_W-1:0] byteIdxReg, byteIdxNext;
  logic [23:0]      packReg, packNext;
  logic [RC_W-1:0]  rstCntReg, rstCntNext;
  logic [CNT_W-1:0] rdAddrReg, rdAddrNext;
  logic             byteReadyReg, cpuResetReg, cpuLoadReg, busyReg, doneReg;

  logic        accept;
  logic        goNow;
  logic        wrEn;
  logic [31:0] slotWord;
  logic [31:0] mergedWord;

  assign accept     = (stateReg == COLLECT) && byte_valid && byteReadyReg;
  assign goNow      = (stateReg == COLLECT) && go;
  // Incoming byte placed in its big-endian slot, merged over the pending bytes;
  // unfilled low bytes stay zero, which gives the padding for a partial word.
  assign slotWord   = {24'd0, byte_in} << {IDX_LAST - byteIdxReg, 3'b000};
  assign mergedWord = {packReg, 8'h00} | (accept ? slotWord : 32'd0);

  // Next-state, packing and counter logic.
  always_comb begin
    stateNext     = stateReg;
    wordCountNext = wordCountReg;
    byteIdxNext   = byteIdxReg;
    packNext      = packReg;
    rstCntNext    = '0;
    wrEn          = 1'b0;
    case (stateReg)
      COLLECT: begin
        if (accept && (byteIdxReg == IDX_LAST || goNow)) begin
          wrEn = 1'b1;
        end else if (goNow && byteIdxReg != '0 && wordCountReg < DEPTH_C) begin
          wrEn = 1'b1;
        end
        if (wrEn) begin
          wordCountNext = wordCountReg + CNT_W'(1);
          byteIdxNext   = '0;
          packNext      = '0;
        end else if (accept) begin
          byteIdxNext = byteIdxReg + IDX_W'(1);
          packNext    = mergedWord[31:8];
        end
        if (goNow) begin
          // Anything still pending here could not be stored; discard it.
          byteIdxNext = '0;
          packNext    = '0;
          stateNext   = CPU_RST;
        end
      end
      CPU_RST: begin
        rstCntNext = rstCntReg + RC_W'(1);
        if (rstCntReg == RST_LAST) begin
          rstCntNext = '0;
          stateNext  = (wordCountReg == '0) ? RELEASE : BURST;
        end
      end
      BURST: begin
        // rdAddrReg is one ahead of the word being presented.
        if (rdAddrReg == wordCountReg) begin
          stateNext = RELEASE;
        end
      end
      RELEASE: stateNext = RUN;
      RUN:     stateNext = RUN;
      default: stateNext = COLLECT;
    endcase
    // Read address is issued on the edge that enters each burst cycle.
    rdAddrNext = (stateNext == BURST) ? rdAddrReg + CNT_W'(1) : '0;
  end

  // State, counters and registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (Reset) begin
      stateReg     <= COLLECT;
      wordCountReg <= '0;
      byteIdxReg   <= '0;
      packReg      <= '0;
      rstCntReg    <= '0;
      rdAddrReg    <= '0;
      byteReadyReg <= 1'b1;
      cpuResetReg  <= 1'b1;
      cpuLoadReg   <= 1'b0;
      busyReg      <= 1'b0;
      doneReg      <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      wordCountReg <= wordCountNext;
      byteIdxReg   <= byteIdxNext;
      packReg      <= packNext;
      rstCntReg    <= rstCntNext;
      rdAddrReg    <= rdAddrNext;
      byteReadyReg <= (stateNext == COLLECT) && (wordCountNext < DEPTH_C);
      cpuResetReg  <= (stateNext == COLLECT) || (stateNext == CPU_RST) ||
                      (stateNext == RELEASE);
      cpuLoadReg   <= (stateNext == BURST);
      busyReg      <= (stateNext == CPU_RST) || (stateNext == BURST) ||
                      (stateNext == RELEASE);
      doneReg      <= (stateNext == RUN);
    end
  end

  loader_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) uBuffer (
    .clk    (clk),
    .wrEn   (wrEn),
    .wrAddr (wordCountReg[AW-1:0]),
    .wrData (mergedWord),
    .rdEn   (stateNext == BURST),
    .rdClr  (Reset || (stateNext != BURST)),
    .rdAddr (rdAddrReg[AW-1:0]),
    .rdData (cpu_instruction)
  );

  assign byte_ready = byteReadyReg;
  assign cpu_reset  = cpuResetReg;
  assign cpu_load   = cpuLoadReg;
  assign word_count = wordCountReg;
  assign busy       = busyReg;
  assign done       = doneReg;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed table plus random loads
// checked against a byte-list/word-list model of the load sequence.
module tb_program_loader;

  localparam int DEPTH      = 32;
  localparam int CNT_W      = $clog2(DEPTH) + 1;
  localparam int RST_CYCLES = 2;

  logic             clk = 1'b0;
  logic             Reset;
  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             byte_ready;
  logic             go;
  logic             cpu_reset;
  logic             cpu_load;
  logic [31:0]      cpu_instruction;
  logic [CNT_W-1:0] word_count;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  program_loader #(
    .DEPTH      (DEPTH),
    .RST_CYCLES (RST_CYCLES)
  ) dut (
    .clk             (clk),
    .Reset           (Reset),
    .byte_in         (byte_in),
    .byte_valid      (byte_valid),
    .byte_ready      (byte_ready),
    .go              (go),
    .cpu_reset       (cpu_reset),
    .cpu_load        (cpu_load),
    .cpu_instruction (cpu_instruction),
    .word_count      (word_count),
    .busy            (busy),
    .done            (done)
  );

  typedef struct {
    int          n;
    logic [63:0] bytes;
    bit          goLast;
    int          expWc;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  vec_t vecs [6];

  int checks = 0;
  int errors = 0;

  logic [7:0]  stimQ [$];
  logic [7:0]  accQ  [$];
  logic [31:0] expW  [$];
  logic [31:0] capQ  [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    Reset      = 1'b1;
    go         = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst cpu_load", 32'(cpu_load), 32'd0);
    check("rst cpu_instruction", cpu_instruction, 32'd0);
    check("rst word_count", 32'(word_count), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    Reset = 1'b0;
    @(posedge clk);
    #1;
    check("post-rst byte_ready", 32'(byte_ready), 32'd1);
  endtask

  // Words the CPU should receive: bytes grouped by four, big-endian,
  // short last group zero-padded, at most DEPTH words kept.
  task automatic buildModel();
    logic [31:0] w;
    expW.delete();
    for (int j = 0; j < accQ.size(); j += 4) begin
      w = 32'd0;
      for (int b = 0; b < 4; b++) begin
        if (j + b < accQ.size()) w = w | (32'(accQ[j + b]) << (24 - 8 * b));
      end
      if (expW.size() < DEPTH) expW.push_back(w);
    end
  endtask

  // Offer stimQ with random idle cycles, then pulse go (optionally with the last byte).
  task automatic sendAndGo(input int idlePct, input bit goWithLast);
    int  i;
    int  budget;
    bit  valid;
    bit  expReady;
    int  expWc;
    bit  goSent;
    accQ.delete();
    i      = 0;
    budget = 0;
    goSent = 1'b0;
    while (i < stimQ.size()) begin
      @(posedge clk);
      #1;
      go       = 1'b0;
      expReady = (accQ.size() < 4 * DEPTH);
      expWc    = (accQ.size() / 4 < DEPTH) ? accQ.size() / 4 : DEPTH;
      check("collect byte_ready", 32'(byte_ready), 32'(expReady));
      check("collect word_count", 32'(word_count), 32'(expWc));
      valid      = ($urandom_range(99) >= idlePct);
      byte_valid = valid;
      byte_in    = valid ? stimQ[i] : 8'($urandom);
      if (valid) begin
        if (expReady) accQ.push_back(stimQ[i]);
        if (goWithLast && i == stimQ.size() - 1) begin
          go     = 1'b1;
          goSent = 1'b1;
        end
        i++;
      end
      budget++;
      if (budget > 5000) begin
        errors++;
        $display("FAIL stimulus budget: got %0d cycles expected under 5000", budget);
        break;
      end
    end
    if (!goSent) begin
      @(posedge clk);
      #1;
      check("go-cycle byte_ready", 32'(byte_ready), 32'(accQ.size() < 4 * DEPTH));
      byte_valid = 1'b0;
      go         = 1'b1;
    end
    buildModel();
  endtask

  // Follow the load cycle by cycle after go; optionally assert Reset at cycle abortAt.
  task automatic traceRun(input int abortAt, input bit tryGoInRun);
    int wc;
    int lat;
    bit inRst, inBurst, inRel, inRun;
    wc  = expW.size();
    lat = RST_CYCLES + wc + 2;
    capQ.delete();
    for (int n = 1; n <= lat + 1; n++) begin
      @(posedge clk);
      #1;
      go         = 1'b0;
      byte_valid = 1'b0;
      inRst   = (n <= RST_CYCLES);
      inBurst = (n > RST_CYCLES) && (n <= RST_CYCLES + wc);
      inRel   = (n == RST_CYCLES + wc + 1);
      inRun   = (n >= lat);
      check("load cpu_reset", 32'(cpu_reset), 32'(inRst || inRel));
      check("load cpu_load", 32'(cpu_load), 32'(inBurst));
      check("load busy", 32'(busy), 32'(!inRun));
      check("load done", 32'(done), 32'(inRun));
      check("load byte_ready", 32'(byte_ready), 32'd0);
      check("load word_count", 32'(word_count), 32'(wc));
      if (cpu_load) capQ.push_back(cpu_instruction);
      if (inBurst) check("burst word", cpu_instruction, expW[n - RST_CYCLES - 1]);
      if (n == abortAt) begin
        Reset = 1'b1;
        $display("load: %0d bytes accepted, aborted at cycle %0d after go", accQ.size(), n);
        return;
      end
    end
    if (tryGoInRun) begin
      go         = 1'b1;
      byte_valid = 1'b1;
      byte_in    = 8'h5A;
      for (int m = 0; m < 3; m++) begin
        @(posedge clk);
        #1;
        go = 1'b0;
        check("run cpu_reset", 32'(cpu_reset), 32'd0);
        check("run cpu_load", 32'(cpu_load), 32'd0);
        check("run done", 32'(done), 32'd1);
        check("run busy", 32'(busy), 32'd0);
        check("run byte_ready", 32'(byte_ready), 32'd0);
        check("run word_count", 32'(word_count), 32'(wc));
      end
      byte_valid = 1'b0;
    end
    $display("load: %0d bytes accepted, %0d words expected, %0d burst words seen",
             accQ.size(), wc, capQ.size());
  endtask

  task automatic loadStim(input vec_t v);
    logic [63:0] bs;
    bs = v.bytes;
    stimQ.delete();
    for (int k = 0; k < v.n; k++) stimQ.push_back(bs[63 - 8 * k -: 8]);
  endtask

  task automatic randStim(input int len);
    stimQ.delete();
    for (int k = 0; k < len; k++) stimQ.push_back(8'($urandom));
  endtask

  initial begin
    vecs[0] = '{n: 8, bytes: 64'h2001_0005_2002_0007, goLast: 1'b0, expWc: 2,
                w0: 32'h2001_0005, w1: 32'h2002_0007};
    vecs[1] = '{n: 5, bytes: 64'hAABB_CCDD_1100_0000, goLast: 1'b0, expWc: 2,
                w0: 32'hAABB_CCDD, w1: 32'h1100_0000};
    vecs[2] = '{n: 0, bytes: 64'h0, goLast: 1'b0, expWc: 0,
                w0: 32'h0, w1: 32'h0};
    vecs[3] = '{n: 3, bytes: 64'h1234_5600_0000_0000, goLast: 1'b1, expWc: 1,
                w0: 32'h1234_5600, w1: 32'h0};
    vecs[4] = '{n: 4, bytes: 64'hDEAD_BEEF_0000_0000, goLast: 1'b1, expWc: 1,
                w0: 32'hDEAD_BEEF, w1: 32'h0};
    vecs[5] = '{n: 6, bytes: 64'h0102_0304_0506_0000, goLast: 1'b1, expWc: 2,
                w0: 32'h0102_0304, w1: 32'h0506_0000};

    // Directed table.
    for (int v = 0; v < 6; v++) begin
      doReset();
      loadStim(vecs[v]);
      sendAndGo(0, vecs[v].goLast);
      traceRun(0, v == 0);
      check("table burst length", 32'(capQ.size()), 32'(vecs[v].expWc));
      if (vecs[v].expWc > 0 && capQ.size() > 0) check("table word0", capQ[0], vecs[v].w0);
      if (vecs[v].expWc > 1 && capQ.size() > 1) check("table word1", capQ[1], vecs[v].w1);
    end

    // Overfill: byte_valid held high past capacity.
    doReset();
    randStim(4 * DEPTH + 4);
    sendAndGo(0, 1'b0);
    traceRun(0, 1'b0);
    check("full burst length", 32'(capQ.size()), 32'(DEPTH));

    // Reset on the third burst cycle of a 10-word load, then a clean 1-word load.
    doReset();
    randStim(40);
    sendAndGo(0, 1'b0);
    traceRun(RST_CYCLES + 3, 1'b0);
    @(posedge clk);
    #1;
    check("abort cpu_load", 32'(cpu_load), 32'd0);
    check("abort cpu_reset", 32'(cpu_reset), 32'd1);
    check("abort word_count", 32'(word_count), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    Reset = 1'b0;
    stimQ.delete();
    stimQ.push_back(8'hC0);
    stimQ.push_back(8'hFF);
    stimQ.push_back(8'hEE);
    stimQ.push_back(8'h01);
    sendAndGo(0, 1'b0);
    traceRun(0, 1'b0);
    check("after-abort burst length", 32'(capQ.size()), 32'd1);
    if (capQ.size() > 0) check("after-abort word", capQ[0], 32'hC0FF_EE01);

    // Random gaps and lengths, go pulsed in RUN.
    for (int r = 0; r < 4; r++) begin
      doReset();
      randStim((r == 0) ? 40 : int'($urandom_range(60, 1)));
      sendAndGo(30, 1'($urandom_range(1)));
      traceRun(0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
